// File: rtl/hex_disp_pkg.sv
// ----------------------------------------------------------------------------
// hex_disp_pkg
// Shared constants for the scanned hexadecimal seven-segment display:
//   SEG_A..SEG_G : bit positions of each segment inside a 7-bit segment word
//   SEG_TABLE    : active-high segment pattern for each hex value 0..F
//   hex_to_seg   : nibble -> active-high segment word
// ----------------------------------------------------------------------------
package hex_disp_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Entry n is the pattern for hex digit n; bit 6 = g ... bit 0 = a.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// ----------------------------------------------------------------------------
// hex_seg_decoder
// Combinational 4-bit hex value to active-high seven-segment pattern.
//   i_nibble : hex value 0..F
//   o_seg    : segment word, bit k = segment k (0 = a ... 6 = g), 1 = lit
// ----------------------------------------------------------------------------
module hex_seg_decoder
   import hex_disp_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/hex_scan_display.sv
// ----------------------------------------------------------------------------
// hex_scan_display
// Time-multiplexed driver for NUM_DIGITS hex seven-segment digits. New digit
// values are captured into a shadow register by a load strobe and only move
// into the display register at a frame boundary, so a frame never shows a
// mix of old and new digits.
//   clock       : single clock
//   resetn      : asynchronous active-low reset
//   load        : one-cycle write strobe for data_in
//   data_in     : nibble k is digit k, digit 0 least significant
//   blank       : live per-digit blank mask, 1 = dark
//   seg         : registered segment drive (polarity set by ACTIVE_LOW)
//   an          : registered one-hot digit enable (polarity set by ACTIVE_LOW)
//   pending     : a load is captured but not yet committed
//   frame_start : registered pulse in the cycle digit 0 of a frame is shown
// ----------------------------------------------------------------------------
module hex_scan_display
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int SCAN_DIV    = 1000,
   parameter int ACTIVE_LOW  = 1,
   parameter int LZ_SUPPRESS = 0
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame_start
);

   localparam int CW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [IW-1:0] IDX_ZERO = IW'(0);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic          POL_LOW  = (ACTIVE_LOW != 0);
   localparam logic          LZ_ON    = (LZ_SUPPRESS != 0);

   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_idx;
   logic [DW-1:0]         r_display;
   logic [DW-1:0]         r_shadow;
   logic                  r_pending;
   logic [6:0]            r_seg;
   logic [NUM_DIGITS-1:0] r_an;
   logic                  r_frame_start;

   logic [CW-1:0]         w_cnt_nxt;
   logic [IW-1:0]         w_idx_nxt;
   logic                  w_cnt_last;
   logic                  w_boundary;
   logic [3:0]            w_nibble;
   logic                  w_blank_sel;
   logic                  w_upper_nz;
   logic                  w_dark;
   logic [NUM_DIGITS-1:0] w_an_hot;
   logic [6:0]            w_seg_dec;
   logic [6:0]            w_seg_hi;
   logic [NUM_DIGITS-1:0] w_an_hi;
   logic [6:0]            w_seg_pin;
   logic [NUM_DIGITS-1:0] w_an_pin;
   logic                  w_frame_start_nxt;

   // Scan position: next counter/idx values and the frame-boundary flag.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_idx_nxt  = r_idx;
      w_cnt_last = (r_cnt == CNT_LAST);
      w_boundary = w_cnt_last && (r_idx == IDX_LAST);
      if (w_cnt_last) begin
         w_cnt_nxt = CNT_ZERO;
         if (r_idx == IDX_LAST) begin
            w_idx_nxt = IDX_ZERO;
         end else begin
            w_idx_nxt = r_idx + IDX_ONE;
         end
      end else begin
         w_cnt_nxt = r_cnt + CNT_ONE;
      end
   end

   // Select the active digit's nibble, blank bit and enable, and detect
   // whether any nibble at or above the active index is non-zero.
   always_comb begin
      w_nibble    = 4'd0;
      w_blank_sel = 1'b0;
      w_an_hot    = {NUM_DIGITS{1'b0}};
      w_upper_nz  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (r_idx == IW'(k)) begin
            w_nibble    = r_display[4*k +: 4];
            w_blank_sel = blank[k];
            w_an_hot[k] = 1'b1;
         end else begin
            w_an_hot[k] = 1'b0;
         end
         if ((IW'(k) >= r_idx) && (r_display[4*k +: 4] != 4'd0)) begin
            w_upper_nz = 1'b1;
         end else begin
            w_upper_nz = w_upper_nz;
         end
      end
   end

   hex_seg_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

   // Dark handling and pin polarity for the next registered output.
   always_comb begin
      // Digit 0 is never leading-zero suppressed, so a zero value still shows.
      w_dark            = w_blank_sel || (LZ_ON && (r_idx != IDX_ZERO) && !w_upper_nz);
      w_frame_start_nxt = (r_cnt == CNT_ZERO) && (r_idx == IDX_ZERO);
      if (w_dark) begin
         w_seg_hi = 7'd0;
         w_an_hi  = {NUM_DIGITS{1'b0}};
      end else begin
         w_seg_hi = w_seg_dec;
         w_an_hi  = w_an_hot;
      end
      if (POL_LOW) begin
         w_seg_pin = ~w_seg_hi;
         w_an_pin  = ~w_an_hi;
      end else begin
         w_seg_pin = w_seg_hi;
         w_an_pin  = w_an_hi;
      end
   end

   // Scan counter and digit index.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt <= CNT_ZERO;
         r_idx <= IDX_ZERO;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_idx <= w_idx_nxt;
      end
   end

   // Shadow capture, pending flag and frame-boundary commit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_shadow  <= {DW{1'b0}};
         r_display <= {DW{1'b0}};
         r_pending <= 1'b0;
      end else if (load && w_boundary) begin
         // A load on the boundary itself bypasses the shadow wait.
         r_shadow  <= data_in;
         r_display <= data_in;
         r_pending <= 1'b0;
      end else if (load) begin
         r_shadow  <= data_in;
         r_pending <= 1'b1;
      end else if (w_boundary && r_pending) begin
         r_display <= r_shadow;
         r_pending <= 1'b0;
      end else begin
         r_pending <= r_pending;
      end
   end

   // Registered pin outputs; reset drives the inactive level.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_seg         <= {7{POL_LOW}};
         r_an          <= {NUM_DIGITS{POL_LOW}};
         r_frame_start <= 1'b0;
      end else begin
         r_seg         <= w_seg_pin;
         r_an          <= w_an_pin;
         r_frame_start <= w_frame_start_nxt;
      end
   end

   assign seg         = r_seg;
   assign an          = r_an;
   assign pending     = r_pending;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_scan_display.sv
// ----------------------------------------------------------------------------
// tb_hex_scan_display
// Two instances share stimulus: A (4 digits, 2 cycles/digit, active-low,
// no suppression) and B (4 digits, 3 cycles/digit, active-high, leading-zero
// suppression). A timeline model derives every output from elapsed cycles.
// ----------------------------------------------------------------------------
module tb_hex_scan_display;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          resetn;
   logic          load;
   logic [15:0]   data_in;
   logic [3:0]    blank;

   logic [6:0]    seg_a, seg_b;
   logic [3:0]    an_a, an_b;
   logic          pend_a, pend_b, fs_a, fs_b;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   hex_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(2), .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut_a (
      .clock(clock), .resetn(resetn), .load(load), .data_in(data_in), .blank(blank),
      .seg(seg_a), .an(an_a), .pending(pend_a), .frame_start(fs_a));

   hex_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(3), .ACTIVE_LOW(0), .LZ_SUPPRESS(1)) dut_b (
      .clock(clock), .resetn(resetn), .load(load), .data_in(data_in), .blank(blank),
      .seg(seg_b), .an(an_b), .pending(pend_b), .frame_start(fs_b));

   // Segment patterns written straight from the decode list (g..a).
   logic [6:0] segs [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   int cfg_sd [2] = '{2, 3};
   int cfg_al [2] = '{1, 0};
   int cfg_lz [2] = '{0, 1};

   int unsigned m_t    [2];
   logic [15:0] m_disp [2];
   logic [15:0] m_shad [2];
   logic        m_pend [2];
   logic [6:0]  e_seg  [2];
   logic [3:0]  e_an   [2];
   logic        e_fs   [2];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Reference timeline: output for a cycle follows from position in the frame.
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int c = 0; c < 2; c++) begin
            m_t[c]    <= 0;
            m_disp[c] <= 16'h0000;
            m_shad[c] <= 16'h0000;
            m_pend[c] <= 1'b0;
            e_seg[c]  <= (cfg_al[c] != 0) ? 7'h7F : 7'h00;
            e_an[c]   <= (cfg_al[c] != 0) ? 4'hF : 4'h0;
            e_fs[c]   <= 1'b0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            int pos, idx, period;
            logic dark;
            logic [6:0] hs;
            logic [3:0] ha;
            period = N * cfg_sd[c];
            pos    = int'(m_t[c] % period);
            idx    = pos / cfg_sd[c];
            dark   = blank[idx] ||
                     ((cfg_lz[c] != 0) && (idx > 0) && ((m_disp[c] >> (4 * idx)) == 16'h0000));
            hs     = dark ? 7'h00 : segs[(m_disp[c] >> (4 * idx)) & 16'h000F];
            ha     = dark ? 4'h0 : (4'h1 << idx);
            e_seg[c] <= (cfg_al[c] != 0) ? ~hs : hs;
            e_an[c]  <= (cfg_al[c] != 0) ? ~ha : ha;
            e_fs[c]  <= (pos == 0);
            if (load && (pos == period - 1)) begin
               m_disp[c] <= data_in;
               m_shad[c] <= data_in;
               m_pend[c] <= 1'b0;
            end else if (load) begin
               m_shad[c] <= data_in;
               m_pend[c] <= 1'b1;
            end else if ((pos == period - 1) && m_pend[c]) begin
               m_disp[c] <= m_shad[c];
               m_pend[c] <= 1'b0;
            end
            m_t[c] <= m_t[c] + 1;
         end
      end
   end

   // Per-cycle comparison of both instances against the timeline.
   always @(negedge clock) begin
      chk("seg_a", {9'd0, seg_a}, {9'd0, e_seg[0]});
      chk("an_a",  {12'd0, an_a}, {12'd0, e_an[0]});
      chk("pend_a", {15'd0, pend_a}, {15'd0, m_pend[0]});
      chk("fs_a",  {15'd0, fs_a}, {15'd0, e_fs[0]});
      chk("seg_b", {9'd0, seg_b}, {9'd0, e_seg[1]});
      chk("an_b",  {12'd0, an_b}, {12'd0, e_an[1]});
      chk("pend_b", {15'd0, pend_b}, {15'd0, m_pend[1]});
      chk("fs_b",  {15'd0, fs_b}, {15'd0, e_fs[1]});
   end

   task automatic do_load(input logic [15:0] v);
      @(negedge clock);
      load    = 1'b1;
      data_in = v;
      @(negedge clock);
      load    = 1'b0;
   endtask

   task automatic wait_fs(input int which, input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if ((which == 0) ? fs_a : fs_b) begin
            ok = 1'b1;
            break;
         end
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: no frame_start within 40 cycles", name);
      end
   endtask

   initial begin
      resetn  = 1'b0;
      load    = 1'b0;
      data_in = 16'h0000;
      blank   = 4'h0;
      repeat (3) @(negedge clock);
      chk("rst_seg_a", {9'd0, seg_a}, 16'h007F);
      chk("rst_an_a",  {12'd0, an_a}, 16'h000F);
      chk("rst_seg_b", {9'd0, seg_b}, 16'h0000);
      chk("rst_an_b",  {12'd0, an_b}, 16'h0000);
      resetn = 1'b1;

      // 0F10 on A: 0, 1, F, 0 in active-low form.
      do_load(16'h0F10);
      repeat (30) @(negedge clock);
      wait_fs(0, "wait_0f10");
      chk("0f10_d0_seg", {9'd0, seg_a}, 16'h0040);
      chk("0f10_d0_an",  {12'd0, an_a}, 16'h000E);
      repeat (2) @(negedge clock);
      chk("0f10_d1_seg", {9'd0, seg_a}, 16'h0079);
      chk("0f10_d1_an",  {12'd0, an_a}, 16'h000D);
      repeat (2) @(negedge clock);
      chk("0f10_d2_seg", {9'd0, seg_a}, 16'h000E);
      repeat (2) @(negedge clock);
      chk("0f10_d3_seg", {9'd0, seg_a}, 16'h0040);

      // 1234 on B (active-high): digit 0 shows 4 with frame_start.
      do_load(16'h1234);
      repeat (30) @(negedge clock);
      wait_fs(1, "wait_1234");
      chk("1234_d0_seg", {9'd0, seg_b}, 16'h0066);

      // Leading-zero suppression on B with 0070.
      do_load(16'h0070);
      repeat (30) @(negedge clock);
      wait_fs(1, "wait_0070");
      chk("lz_d0_seg", {9'd0, seg_b}, 16'h003F);
      chk("lz_d0_an",  {12'd0, an_b}, 16'h0001);
      repeat (3) @(negedge clock);
      chk("lz_d1_seg", {9'd0, seg_b}, 16'h0007);
      repeat (3) @(negedge clock);
      chk("lz_d2_an",  {12'd0, an_b}, 16'h0000);
      chk("lz_d2_seg", {9'd0, seg_b}, 16'h0000);

      // Blank digit 2 on A.
      blank = 4'b0100;
      wait_fs(0, "wait_blank");
      repeat (4) @(negedge clock);
      chk("blank_d2_an",  {12'd0, an_a}, 16'h000F);
      chk("blank_d2_seg", {9'd0, seg_a}, 16'h007F);
      blank = 4'b0000;

      // Randomised loads and blank changes.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clock);
         load = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < 4; k++) begin
            data_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         end
         if ($urandom_range(0, 31) == 0) begin
            blank = 4'($urandom_range(0, 15));
         end
      end

      // Asynchronous reset with a load pending.
      @(negedge clock);
      load    = 1'b0;
      blank   = 4'h0;
      do_load(16'hBEEF);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_seg_a", {9'd0, seg_a}, 16'h007F);
      chk("arst_an_a",  {12'd0, an_a}, 16'h000F);
      chk("arst_seg_b", {9'd0, seg_b}, 16'h0000);
      chk("arst_pend",  {14'd0, pend_a, pend_b}, 16'h0000);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("rel_fs",    {14'd0, fs_a, fs_b}, 16'h0003);
      chk("rel_seg_a", {9'd0, seg_a}, 16'h0040);
      chk("rel_an_a",  {12'd0, an_a}, 16'h000E);
      chk("rel_seg_b", {9'd0, seg_b}, 16'h003F);
      repeat (20) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
